// File: rtl/conv_pool_if.sv
// Handshake bundle between the convolution stage and the 2x2 pooling stage.
// The master side feeds OFM samples in and receives pooled results.
// The slave side is the pooling block itself.
interface conv_pool_if;
   logic        in_valid;
   logic [12:0] In_OFM;
   logic        out_valid;
   logic [12:0] Out_Pool;
   logic        frame_done;

   modport master (
      output in_valid,
      output In_OFM,
      input  out_valid,
      input  Out_Pool,
      input  frame_done
   );

   modport slave (
      input  in_valid,
      input  In_OFM,
      output out_valid,
      output Out_Pool,
      output frame_done
   );
endinterface

// File: rtl/conv_pool.sv
// conv_pool: 2x2 / stride-2 pooling over a MAP_W x MAP_H OFM streamed in
// row-major order, one sample per in_valid cycle.
//
// Build option: define POOL_AVG_EN for average pooling (sum of the four
// samples >> 2, truncated). Without it the block does max pooling.
// Timing, counters and frame_done behave identically in both builds.
//
// Data path:
//   even column -> sample parked in hold_reg
//   odd column  -> hold_reg combined with the current sample = horizontal partial
//   even row    -> partial written to line_buf[col/2]
//   odd row     -> partial combined with line_buf[col/2] = window result,
//                  registered onto Out_Pool with a one-cycle out_valid pulse.
//
// The line buffer has a registered read port. The entry needed on an odd
// row is fetched when that window's even-column sample is accepted, so it
// is already sitting in rd_reg when the odd-column sample arrives.
// rst_n is active-high despite its name.
module conv_pool #(
   parameter int MAP_W = 4,
   parameter int MAP_H = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   conv_pool_if.slave  io
);

   localparam int CW       = (MAP_W > 2) ? $clog2(MAP_W) : 1;
   localparam int RW       = (MAP_H > 2) ? $clog2(MAP_H) : 1;
   localparam int LB_DEPTH = MAP_W / 2;
   localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
`ifdef POOL_AVG_EN
   localparam int PW = 14;
`else
   localparam int PW = 13;
`endif

   localparam logic [CW-1:0] COL_LAST = CW'(MAP_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(MAP_H - 1);

   // position counters and horizontal holding register
   logic [CW-1:0] col_reg, col_next;
   logic [RW-1:0] row_reg, row_next;
   logic [12:0]   hold_reg, hold_next;

   // registered outputs
   logic          out_valid_reg, out_valid_next;
   logic [12:0]   out_pool_reg, out_pool_next;
   logic          frame_done_reg, frame_done_next;

   // line buffer (one horizontal partial per output column) and its read register
   logic [14:0]   line_buf [LB_DEPTH];
   logic [14:0]   rd_reg;
   logic [LBW-1:0] lb_idx;

   // datapath intermediates
   logic [PW-1:0] partial;
   logic [12:0]   window_val;
   logic          col_odd, row_odd, col_last, row_last;

   assign col_odd  = col_reg[0];
   assign row_odd  = row_reg[0];
   assign col_last = (col_reg == COL_LAST);
   assign row_last = (row_reg == ROW_LAST);
   assign lb_idx   = LBW'(col_reg >> 1);

   // horizontal partial and full-window result for the current sample
   always_comb begin
      partial    = '0;
      window_val = '0;
`ifdef POOL_AVG_EN
      partial    = 14'(hold_reg) + 14'(io.In_OFM);
      window_val = 13'((rd_reg + 15'(partial)) >> 2);
`else
      partial    = (io.In_OFM > hold_reg) ? io.In_OFM : hold_reg;
      window_val = (rd_reg > 15'(partial)) ? 13'(rd_reg) : partial;
`endif
   end

   // next-state logic: counters, hold register and output pulses
   always_comb begin
      col_next        = col_reg;
      row_next        = row_reg;
      hold_next       = hold_reg;
      out_valid_next  = 1'b0;
      out_pool_next   = out_pool_reg;
      frame_done_next = 1'b0;

      if (io.in_valid) begin
         if (!col_odd) begin
            hold_next = io.In_OFM;
         end

         if (col_last) begin
            col_next = '0;
            row_next = row_last ? '0 : row_reg + RW'(1);
         end else begin
            col_next = col_reg + CW'(1);
         end

         if (row_odd && col_odd) begin
            out_valid_next  = 1'b1;
            out_pool_next   = window_val;
            frame_done_next = row_last && col_last;
         end
      end
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         col_reg        <= '0;
         row_reg        <= '0;
         hold_reg       <= '0;
         out_valid_reg  <= 1'b0;
         out_pool_reg   <= '0;
         frame_done_reg <= 1'b0;
      end else begin
         col_reg        <= col_next;
         row_reg        <= row_next;
         hold_reg       <= hold_next;
         out_valid_reg  <= out_valid_next;
         out_pool_reg   <= out_pool_next;
         frame_done_reg <= frame_done_next;
      end
   end

   // line buffer: write partials on even rows, prefetch the entry on odd rows
   always_ff @(posedge clk) begin
      if (io.in_valid && !row_odd && col_odd) begin
         line_buf[lb_idx] <= 15'(partial);
      end
      if (io.in_valid && row_odd && !col_odd) begin
         rd_reg <= line_buf[lb_idx];
      end
   end

   assign io.out_valid  = out_valid_reg;
   assign io.Out_Pool   = out_pool_reg;
   assign io.frame_done = frame_done_reg;

endmodule

// File: tb/tb_conv_pool.sv
// Directed bench for conv_pool on a 4x4 map. Every cycle after a sample or
// idle slot, out_valid / Out_Pool / frame_done are compared with values
// worked out by hand for the ramp (0..15) and all-ones (8191) frames.
// Expected ramp results follow the build option POOL_AVG_EN.
module tb_conv_pool;
   localparam int MAP_W = 4;
   localparam int MAP_H = 4;

   logic clk;
   logic rst_n;

   conv_pool_if pool_bus ();

   conv_pool #(.MAP_W(MAP_W), .MAP_H(MAP_H)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (pool_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          out_count = 0;
   int          ramp_exp [4];
   logic [12:0] last_pool = '0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // one cycle with no sample: nothing may be emitted, Out_Pool must hold
   task automatic idle_cycle();
      pool_bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("idle_valid", int'(pool_bus.out_valid), 0);
      check("idle_done", int'(pool_bus.frame_done), 0);
      check("idle_hold", int'(pool_bus.Out_Pool), int'(last_pool));
   endtask

   // one accepted sample at frame position s, then check the cycle after
   task automatic send(input int s, input int v, input int exp_val);
      int  row;
      int  col;
      bit  win_end;
      row = s / MAP_W;
      col = s % MAP_W;
      win_end = (row % 2 == 1) && (col % 2 == 1);
      pool_bus.in_valid = 1'b1;
      pool_bus.In_OFM   = 13'(v);
      @(posedge clk);
      #1;
      check("out_valid", int'(pool_bus.out_valid), int'(win_end));
      check("frame_done", int'(pool_bus.frame_done), int'(s == MAP_W * MAP_H - 1));
      if (win_end) begin
         check("out_pool", int'(pool_bus.Out_Pool), exp_val);
         last_pool = 13'(exp_val);
         out_count++;
         $display("[%0t] pool out #%0d value=%0d frame_done=%0d", $time, out_count,
                  pool_bus.Out_Pool, pool_bus.frame_done);
      end else begin
         check("hold", int'(pool_bus.Out_Pool), int'(last_pool));
      end
   endtask

   // mode 0: ramp s, mode 1: all 8191; gaps of 0..max_gap idle cycles
   task automatic run_frame(input int mode, input int max_gap, input int n_samples);
      for (int s = 0; s < n_samples; s++) begin
         int gap;
         int row;
         int col;
         int w;
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (gap) idle_cycle();
         row = s / MAP_W;
         col = s % MAP_W;
         w = (row / 2) * (MAP_W / 2) + col / 2;
         if (mode == 0) send(s, s, ramp_exp[w]);
         else           send(s, 8191, 8191);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, int'(pool_bus.out_valid), 0);
      check({tag, "_pool"}, int'(pool_bus.Out_Pool), 0);
      check({tag, "_done"}, int'(pool_bus.frame_done), 0);
   endtask

   task automatic do_reset();
      pool_bus.in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      check_cleared("rst_async");
      repeat (2) @(posedge clk);
      #1;
      check_cleared("rst_hold");
      rst_n = 1'b0;
      last_pool = '0;
      idle_cycle();
   endtask

   initial begin
`ifdef POOL_AVG_EN
      ramp_exp = '{2, 4, 10, 12};
`else
      ramp_exp = '{5, 7, 13, 15};
`endif
      rst_n = 1'b0;
      pool_bus.in_valid = 1'b0;
      pool_bus.In_OFM   = '0;
      #2;
      rst_n = 1'b1;
      #1;
      check_cleared("rst_init");
      repeat (3) @(posedge clk);
      #1;
      check_cleared("rst_init_hold");
      rst_n = 1'b0;
      repeat (2) idle_cycle();

      $display("ramp frame, continuous");
      run_frame(0, 0, 16);
      idle_cycle();

      $display("ramp frame, random gaps");
      run_frame(0, 5, 16);
      repeat (3) idle_cycle();

      $display("all-8191 frame");
      run_frame(1, 0, 16);
      idle_cycle();

      $display("reset after 6 samples, then ramp frame");
      run_frame(0, 0, 6);
      do_reset();
      run_frame(0, 0, 16);
      idle_cycle();

      $display("two back-to-back ramp frames");
      run_frame(0, 0, 16);
      run_frame(0, 0, 16);
      repeat (2) idle_cycle();

      check("output_count", out_count, 4 + 4 + 4 + 1 + 4 + 8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
